// File: rtl/iob_wishbone2iob.sv
// Wishbone slave to IOb master bridge: one outstanding request, registered
// outputs, IOb-side timeout, and silent draining of requests abandoned by the master.
module iob_wishbone2iob #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [ADDR_W-1:0]   wb_addr_i,
   input  logic [DATA_W-1:0]   wb_data_i,
   input  logic [DATA_W/8-1:0] wb_select_i,
   input  logic                wb_we_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   output logic [DATA_W-1:0]   wb_data_o,
   output logic                wb_ack_o,
   output logic                wb_error_o,
   output logic                valid_o,
   output logic [ADDR_W-1:0]   address_o,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [DATA_W/8-1:0] wstrb_o,
   input  logic [DATA_W-1:0]   rdata_i,
   input  logic                ready_i
);

   localparam int STRB_W = DATA_W / 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_ACK   = 3'd2;
   localparam logic [2:0] ST_ERR   = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   // Counter value seen on the edge that completes the limit of waiting cycles.
   localparam logic [TIMEOUT_W-1:0] LAST_COUNT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   logic [2:0]           state_reg;
   logic [TIMEOUT_W-1:0] count_reg;
   logic [DATA_W-1:0]    rdata_reg;
   logic                 ack_reg;
   logic                 error_reg;
   logic                 valid_reg;
   logic [ADDR_W-1:0]    address_reg;
   logic [DATA_W-1:0]    wdata_reg;
   logic [STRB_W-1:0]    wstrb_reg;

   logic [STRB_W-1:0]    req_strb;
   logic                 request;
   logic                 timeout_hit;
   logic                 is_read;

   // Reads carry an all-zero strobe, so byte selects only pass through on writes.
   generate
      for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
         assign req_strb[gi] = wb_select_i[gi] & wb_we_i;
      end
   endgenerate

   assign request     = wb_cyc_i & wb_stb_i;
   assign timeout_hit = (count_reg == LAST_COUNT);
   assign is_read     = (wstrb_reg == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= ST_IDLE;
         count_reg   <= '0;
         rdata_reg   <= '0;
         ack_reg     <= 1'b0;
         error_reg   <= 1'b0;
         valid_reg   <= 1'b0;
         address_reg <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (request) begin
                  address_reg <= wb_addr_i;
                  wdata_reg   <= wb_data_i;
                  wstrb_reg   <= req_strb;
                  valid_reg   <= 1'b1;
                  count_reg   <= '0;
                  state_reg   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // ready beats the timeout; a master that already left gets no response.
               if (ready_i) begin
                  valid_reg <= 1'b0;
                  if (wb_cyc_i) begin
                     ack_reg   <= 1'b1;
                     state_reg <= ST_ACK;
                     if (is_read) begin
                        rdata_reg <= rdata_i;
                     end
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else if (timeout_hit) begin
                  valid_reg <= 1'b0;
                  if (wb_cyc_i) begin
                     error_reg <= 1'b1;
                     state_reg <= ST_ERR;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else begin
                  count_reg <= count_reg + TIMEOUT_W'(1);
                  if (!wb_cyc_i) begin
                     state_reg <= ST_DRAIN;
                  end
               end
            end
            ST_ACK: begin
               ack_reg   <= 1'b0;
               state_reg <= ST_IDLE;
            end
            ST_ERR: begin
               error_reg <= 1'b0;
               state_reg <= ST_IDLE;
            end
            ST_DRAIN: begin
               // The IOb request stays up until the slave answers or gives up.
               if (ready_i || timeout_hit) begin
                  valid_reg <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  count_reg <= count_reg + TIMEOUT_W'(1);
               end
            end
            default: begin
               valid_reg <= 1'b0;
               ack_reg   <= 1'b0;
               error_reg <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign wb_data_o  = rdata_reg;
   assign wb_ack_o   = ack_reg;
   assign wb_error_o = error_reg;
   assign valid_o    = valid_reg;
   assign address_o  = address_reg;
   assign wdata_o    = wdata_reg;
   assign wstrb_o    = wstrb_reg;

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Bench for iob_wishbone2iob: table-driven transactions with a read-data
// scoreboard, plus hand-written back-to-back, timeout, abort and reset sequences.
module tb_iob_wishbone2iob;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int TIMEOUT_W = 4;
   localparam int LIMIT     = 15;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_wdata;
   logic [3:0]        wb_sel;
   logic              wb_we;
   logic              wb_cyc;
   logic              wb_stb;
   logic [DATA_W-1:0] wb_rdata;
   logic              wb_ack;
   logic              wb_err;
   logic              valid;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        wstrb;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   iob_wishbone2iob #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wb_addr_i  (wb_addr),
      .wb_data_i  (wb_wdata),
      .wb_select_i(wb_sel),
      .wb_we_i    (wb_we),
      .wb_cyc_i   (wb_cyc),
      .wb_stb_i   (wb_stb),
      .wb_data_o  (wb_rdata),
      .wb_ack_o   (wb_ack),
      .wb_error_o (wb_err),
      .valid_o    (valid),
      .address_o  (address),
      .wdata_o    (wdata),
      .wstrb_o    (wstrb),
      .rdata_i    (rdata),
      .ready_i    (ready)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      logic        we;
      int          delay;
      logic [31:0] rdata;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_data;
   } vec_t;

   vec_t        vecs[4];
   logic [31:0] sb_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          both_seen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wb_ack && wb_err) both_seen = 1'b1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic check_ack_data(input string name);
      logic [31:0] exp;
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty at ack, got 0x%0h expected none", name, wb_rdata);
      end else begin
         exp = sb_q.pop_front();
         check(name, wb_rdata, exp);
      end
   endtask

   task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic w);
      wb_addr  = a;
      wb_wdata = d;
      wb_sel   = s;
      wb_we    = w;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
   endtask

   task automatic drop_req();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
   endtask

   // Called at a negedge with the bridge idle; returns at a negedge with it idle.
   task automatic run_txn(input vec_t v, input int idx);
      drive_req(v.addr, v.data, v.sel, v.we);
      sb_q.push_back(v.exp_data);
      @(posedge clk);
      @(negedge clk);
      check("txn_valid", valid, 1);
      check("txn_addr", address, v.addr);
      check("txn_wdata", wdata, v.data);
      check("txn_wstrb", wstrb, v.exp_wstrb);
      for (int i = 0; i < v.delay; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("txn_wait_valid", valid, 1);
         check("txn_wait_ack", wb_ack, 0);
      end
      check("txn_wstrb_stable", wstrb, v.exp_wstrb);
      ready = 1'b1;
      rdata = v.rdata;
      @(posedge clk);
      @(negedge clk);
      ready = 1'b0;
      check("txn_ack", wb_ack, 1);
      check("txn_no_err", wb_err, 0);
      check("txn_valid_low", valid, 0);
      check_ack_data("txn_data");
      drop_req();
      @(posedge clk);
      @(negedge clk);
      check("txn_ack_pulse", wb_ack, 0);
      $display("txn %0d: addr=0x%0h we=%0b wstrb=0x%0h data_o=0x%0h", idx, v.addr, v.we,
               v.exp_wstrb, wb_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 3, 32'h0000_0000, 4'hF, 32'h0000_0000};
      vecs[1] = '{32'h20, 32'h0000_0000, 4'h3, 1'b0, 1, 32'h1234_5678, 4'h0, 32'h1234_5678};
      vecs[2] = '{32'h24, 32'hA5A5_5A5A, 4'h5, 1'b1, 0, 32'hFFFF_FFFF, 4'h5, 32'h1234_5678};
      vecs[3] = '{32'h30, 32'h0000_0000, 4'hF, 1'b0, 5, 32'hCAFE_F00D, 4'h0, 32'hCAFE_F00D};

      rst   = 1'b1;
      ready = 1'b0;
      rdata = '0;
      drive_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_ack", wb_ack, 0);
      check("rst_err", wb_err, 0);
      check("rst_addr", address, 0);
      check("rst_wdata", wdata, 0);
      check("rst_wstrb", wstrb, 0);
      check("rst_data", wb_rdata, 0);
      $display("reset: valid=%0b ack=%0b err=%0b", valid, wb_ack, wb_err);
      drop_req();
      rst = 1'b0;

      // Strobe without cycle is not a request.
      wb_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("stb_no_cyc", valid, 0);
      $display("stb without cyc: valid=%0b", valid);
      wb_stb = 1'b0;

      for (int i = 0; i < 4; i++) run_txn(vecs[i], i);

      // Zero-wait slave with back-to-back reads: one request every 3 cycles.
      ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive_req(32'h100 + 32'(k * 4), 32'h0, 4'hF, 1'b0);
         rdata = 32'h1111_0000 + 32'(k);
         sb_q.push_back(32'h1111_0000 + 32'(k));
         @(posedge clk);
         @(negedge clk);
         check("b2b_valid", valid, 1);
         check("b2b_addr", address, 32'h100 + 32'(k * 4));
         check("b2b_ack_early", wb_ack, 0);
         @(posedge clk);
         @(negedge clk);
         check("b2b_ack", wb_ack, 1);
         check_ack_data("b2b_data");
         @(posedge clk);
         @(negedge clk);
         check("b2b_ack_pulse", wb_ack, 0);
         check("b2b_idle_valid", valid, 0);
         $display("b2b read %0d: addr=0x%0h data_o=0x%0h", k, 32'h100 + 32'(k * 4), wb_rdata);
      end
      ready = 1'b0;
      drop_req();

      // Timeout with no ready: valid high for LIMIT cycles then an error pulse.
      drive_req(32'h50, 32'h0, 4'hF, 1'b0);
      for (int i = 0; i < LIMIT; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("to_valid", valid, 1);
         check("to_no_err", wb_err, 0);
      end
      @(posedge clk);
      @(negedge clk);
      check("to_err", wb_err, 1);
      check("to_no_ack", wb_ack, 0);
      check("to_valid_low", valid, 0);
      check("to_data_kept", wb_rdata, 32'h1111_0002);
      drop_req();
      @(posedge clk);
      @(negedge clk);
      check("to_err_pulse", wb_err, 0);
      $display("timeout: err pulse seen, valid=%0b", valid);

      // Ready arriving on the limit cycle wins over the timeout.
      drive_req(32'h54, 32'h0, 4'hF, 1'b0);
      for (int i = 0; i < LIMIT; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("tol_valid", valid, 1);
      end
      ready = 1'b1;
      rdata = 32'h5555_AAAA;
      sb_q.push_back(32'h5555_AAAA);
      @(posedge clk);
      @(negedge clk);
      ready = 1'b0;
      check("tol_ack", wb_ack, 1);
      check("tol_no_err", wb_err, 0);
      check_ack_data("tol_data");
      drop_req();
      @(posedge clk);
      @(negedge clk);
      check("tol_ack_pulse", wb_ack, 0);
      check("tol_err_quiet", wb_err, 0);
      $display("timeout-limit ready: data_o=0x%0h", wb_rdata);

      // Master abandons the cycle: request drained silently.
      drive_req(32'h60, 32'h0, 4'hF, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("ab_valid", valid, 1);
      drop_req();
      @(posedge clk);
      @(negedge clk);
      check("ab_hold1", valid, 1);
      check("ab_no_ack1", wb_ack, 0);
      @(posedge clk);
      @(negedge clk);
      check("ab_hold2", valid, 1);
      ready = 1'b1;
      rdata = 32'h7777_7777;
      @(posedge clk);
      @(negedge clk);
      ready = 1'b0;
      check("ab_valid_low", valid, 0);
      check("ab_no_ack", wb_ack, 0);
      check("ab_no_err", wb_err, 0);
      check("ab_data_kept", wb_rdata, 32'h5555_AAAA);
      $display("abort: drained, data_o=0x%0h", wb_rdata);
      run_txn('{32'h40, 32'h0, 4'hF, 1'b0, 2, 32'h0BAD_C0DE, 4'h0, 32'h0BAD_C0DE}, 4);

      // Reset while waiting, then a late ready.
      drive_req(32'h70, 32'h1212_1212, 4'hF, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("rw_valid", valid, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drop_req();
      check("rw_valid0", valid, 0);
      check("rw_ack0", wb_ack, 0);
      check("rw_err0", wb_err, 0);
      check("rw_addr0", address, 0);
      check("rw_wdata0", wdata, 0);
      check("rw_wstrb0", wstrb, 0);
      check("rw_data0", wb_rdata, 0);
      @(posedge clk);
      @(negedge clk);
      ready = 1'b1;
      rdata = 32'h9999_9999;
      @(posedge clk);
      @(negedge clk);
      ready = 1'b0;
      check("rw_late_ack", wb_ack, 0);
      check("rw_late_valid", valid, 0);
      @(posedge clk);
      @(negedge clk);
      check("rw_late_ack2", wb_ack, 0);
      check("rw_late_data", wb_rdata, 0);
      $display("reset in wait: outputs cleared, late ready ignored");

      check("ack_err_exclusive", both_seen, 0);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
